// File: rtl/pi_link_pkg.sv
// rtl/pi_link_pkg.sv - shared types and constants for the Pi byte-link frame loader
package pi_link_pkg;

  // Frame parser states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Header byte layout: {bank[1:0], last[5:0]}
  localparam int BANK_MSB = 7;
  localparam int BANK_LSB = 6;
  localparam int LEN_MSB  = 5;
  localparam int LEN_LSB  = 0;

  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;

  // One-hot write strobe for a bank index
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] bank);
    return NUM_BANKS'(1) << bank;
  endfunction

endpackage

// File: rtl/pi_link_timer.sv
// rtl/pi_link_timer.sv - idle-gap watchdog counter for in-frame byte spacing
module pi_link_timer
  import pi_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Expiry is flagged combinationally on the cycle whose edge would complete
  // TIMEOUT_CYCLES strobe-free cycles, so the caller reacts on that same edge.
  assign expired = run && !clear && (cnt == LAST);

  // Count strobe-free cycles while a frame is open; restart on any strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || clear || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pi_load_ctrl.sv
// rtl/pi_load_ctrl.sv - framed SYNC/header/data/checksum loader into four memory banks
module pi_load_ctrl
  import pi_link_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 pi_clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    gpio_pin,
  input  logic                 write_enable,
  output logic [NUM_BANKS-1:0] mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [NUM_BANKS-1:0] bank_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [5:0]           LED
);

  state_t state, state_next;

  logic [1:0]        bank_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] chk_q;

  logic hdr_take;
  logic data_take;
  logic chk_take;
  logic timeout;
  logic expired;

  assign busy = (state != IDLE);
  assign LED  = {err, busy, bank_ready};

  pi_link_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (pi_clk),
    .rst_n  (rst_n),
    .run    (busy),
    .clear  (write_enable),
    .expired(expired)
  );

  // State register
  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-byte action selects; a SYNC value seen
  // after the header is plain payload, there is no mid-frame resync
  always_comb begin
    state_next = state;
    hdr_take   = 1'b0;
    data_take  = 1'b0;
    chk_take   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (write_enable && (gpio_pin == SYNC_BYTE)) begin
          state_next = HDR;
        end
      end
      HDR: begin
        if (expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (write_enable) begin
          hdr_take   = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (write_enable) begin
          data_take = 1'b1;
          if (addr_q == last_q) begin
            state_next = CHK;
          end
        end
      end
      CHK: begin
        if (expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (write_enable) begin
          chk_take   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame context: bank, length, running xor and address counter
  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      last_q <= '0;
      addr_q <= '0;
      chk_q  <= '0;
    end else if (hdr_take) begin
      bank_q <= gpio_pin[BANK_MSB:BANK_LSB];
      last_q <= gpio_pin[LEN_MSB:LEN_LSB];
      addr_q <= '0;
      chk_q  <= gpio_pin;
    end else if (data_take) begin
      addr_q <= addr_q + 1'b1;
      chk_q  <= chk_q ^ gpio_pin;
    end
  end

  // Registered memory write port; address and data hold between writes
  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= '0;
      if (data_take) begin
        mem_we    <= bank_onehot(bank_q);
        mem_addr  <= addr_q;
        mem_wdata <= gpio_pin;
      end
    end
  end

  // Frame outcome: bank_ready per bank, done pulse, sticky err
  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_ready <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hdr_take) begin
        bank_ready[gpio_pin[BANK_MSB:BANK_LSB]] <= 1'b0;
        err <= 1'b0;
      end
      if (chk_take) begin
        if (gpio_pin == chk_q) begin
          bank_ready[bank_q] <= 1'b1;
          done <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pi_load_ctrl.sv
// tb/tb_pi_load_ctrl.sv - self-checking bench for the framed bank loader
module tb_pi_load_ctrl;

  typedef logic [7:0] byte_q_t[$];

  logic       pi_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gpio_pin = 8'h00;
  logic       write_enable = 1'b0;
  logic [3:0] mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [3:0] bank_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] LED;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int wr_exp = 0;
  int done_seen = 0;

  logic [3:0] m_ready = 4'b0;
  logic       m_err = 1'b0;

  always #5 pi_clk = ~pi_clk;

  pi_load_ctrl dut (
    .pi_clk      (pi_clk),
    .rst_n       (rst_n),
    .gpio_pin    (gpio_pin),
    .write_enable(write_enable),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .bank_ready  (bank_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .LED         (LED)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, then sample at the following negedge
  task automatic cyc(input logic we, input logic [7:0] b);
    write_enable = we;
    gpio_pin     = b;
    @(negedge pi_clk);
    if (mem_we !== 4'b0) wr_seen++;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic send(input logic [7:0] b, input int gmin, input int gmax);
    int g;
    g = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
    repeat (g) cyc(1'b0, 8'($urandom));
    cyc(1'b1, b);
  endtask

  function automatic logic [7:0] frame_sum(input logic [1:0] bank, input byte_q_t data);
    logic [7:0] s;
    s = {bank, 6'(data.size() - 1)};
    foreach (data[i]) s ^= data[i];
    return s;
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".ready"}, bank_ready, m_ready);
    check({tag, ".err"}, err, m_err);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".led"}, LED, {m_err, 1'b0, m_ready});
  endtask

  task automatic send_frame(input string tag, input logic [1:0] bank, input byte_q_t data,
                            input logic [7:0] chk, input int gmin, input int gmax);
    logic good;
    int   d0;
    good = (chk == frame_sum(bank, data));
    d0   = done_seen;
    send(8'hA5, gmin, gmax);
    send({bank, 6'(data.size() - 1)}, gmin, gmax);
    m_ready[bank] = 1'b0;
    m_err         = 1'b0;
    check({tag, ".hdr_busy"}, busy, 1'b1);
    check({tag, ".hdr_err"}, err, 1'b0);
    check({tag, ".hdr_ready"}, bank_ready, m_ready);
    foreach (data[i]) begin
      send(data[i], gmin, gmax);
      wr_exp++;
      check($sformatf("%s.wr%0d", tag, i), {mem_we, mem_addr, mem_wdata},
            {4'b0001 << bank, 6'(i), data[i]});
    end
    send(chk, gmin, gmax);
    check({tag, ".done"}, done, good);
    if (good) m_ready[bank] = 1'b1;
    else m_err = 1'b1;
    check_status(tag);
    cyc(1'b0, 8'h00);
    check({tag, ".done_off"}, done, 1'b0);
    check({tag, ".done_cnt"}, done_seen - d0, {31'b0, good});
    check({tag, ".wr_cnt"}, wr_seen, wr_exp);
  endtask

  initial begin
    byte_q_t    d;
    logic [7:0] b;
    logic [1:0] bk;
    int         len;

    repeat (2) @(negedge pi_clk);
    rst_n = 1'b1;
    @(negedge pi_clk);
    check("rst.we", mem_we, 4'b0);
    check("rst.addr", mem_addr, 6'b0);
    check("rst.wdata", mem_wdata, 8'b0);
    check("rst.ready", bank_ready, 4'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.led", LED, 6'b0);

    // Bad checksum into bank 3
    d = '{8'h7E};
    send_frame("badchk", 2'd3, d, 8'h00, 0, 0);
    check("badchk.led_abs", LED, 6'b100000);

    // Good 3-byte frame into bank 0, strobe held high
    d = '{8'h11, 8'h22, 8'h33};
    send_frame("good", 2'd0, d, 8'h02, 0, 0);
    check("good.ready_abs", bank_ready, 4'b0001);
    check("good.led_abs", LED, 6'b000001);

    // Noise bytes in IDLE, then a bank-1 frame with header 41
    d = '{8'h00, 8'hFF, 8'h5A};
    foreach (d[i]) begin
      cyc(1'b1, d[i]);
      check($sformatf("noise%0d.we", i), mem_we, 4'b0);
      check($sformatf("noise%0d.busy", i), busy, 1'b0);
    end
    d = '{8'h99, 8'hD8};
    send_frame("noise_frame", 2'd1, d, frame_sum(2'd1, d), 0, 0);
    check("noise_frame.rdy1", bank_ready[1], 1'b1);

    // Randomized frames with random gaps, noise and corrupted checksums
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(2, 0)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        cyc(1'b1, b);
        check("rnd.noise_we", mem_we, 4'b0);
      end
      bk  = (k == 0) ? 2'd2 : 2'($urandom);
      len = (k == 3) ? 64 : int'($urandom_range(8, 1));
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      b = frame_sum(bk, d);
      if ($urandom_range(3, 0) == 0) b = b ^ 8'($urandom_range(255, 1));
      send_frame($sformatf("rnd%0d", k), bk, d, b, 0, (k % 2 == 0) ? 0 : 2);
    end

    // Timeout: A5, 80, 01 then a long silent gap
    send(8'hA5, 0, 0);
    send(8'h80, 0, 0);
    m_ready[2] = 1'b0;
    m_err      = 1'b0;
    send(8'h01, 0, 0);
    wr_exp++;
    check("to.wr", {mem_we, mem_addr, mem_wdata}, {4'b0100, 6'd0, 8'h01});
    for (int i = 1; i <= 1024; i++) begin
      cyc(1'b0, 8'($urandom));
      if (i == 1023) begin
        check("to.busy_pre", busy, 1'b1);
        check("to.err_pre", err, 1'b0);
      end
    end
    m_err = 1'b1;
    check_status("to");

    // Following bank-2 frame clears err and sets bank_ready[2]
    d = '{8'h5D, 8'hA5};
    send_frame("after_to", 2'd2, d, frame_sum(2'd2, d), 0, 0);
    check("after_to.rdy2", bank_ready[2], 1'b1);

    // Max-length frame, strobe every third cycle, SYNC value as data
    d.delete();
    for (int i = 0; i < 64; i++) d.push_back((i % 9 == 4) ? 8'hA5 : 8'($urandom));
    send_frame("gap64", 2'd0, d, frame_sum(2'd0, d), 2, 2);

    // Reset mid-frame after the second data byte
    send(8'hA5, 0, 0);
    send(8'h03, 0, 0);
    send(8'h12, 0, 0);
    wr_exp++;
    send(8'h34, 0, 0);
    wr_exp++;
    check("midrst.wr1", {mem_we, mem_addr, mem_wdata}, {4'b0001, 6'd1, 8'h34});
    #2 rst_n = 1'b0;
    #1;
    m_ready = 4'b0;
    m_err   = 1'b0;
    check("midrst.we", mem_we, 4'b0);
    check("midrst.addr", mem_addr, 6'b0);
    check("midrst.wdata", mem_wdata, 8'b0);
    check("midrst.ready", bank_ready, 4'b0);
    check("midrst.busy", busy, 1'b0);
    check("midrst.done", done, 1'b0);
    check("midrst.err", err, 1'b0);
    check("midrst.led", LED, 6'b0);
    @(negedge pi_clk);
    rst_n = 1'b1;
    @(negedge pi_clk);

    d = '{8'hC3, 8'h00, 8'h7F};
    send_frame("fresh", 2'd0, d, frame_sum(2'd0, d), 0, 1);
    check("fresh.ready_abs", bank_ready, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
